// File: rtl/ifetch_stage_if.sv
// rtl/ifetch_stage_if.sv - fetch-stage bus: next-PC, redirect, imem handshake, IF/ID outputs
interface ifetch_stage_if;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        input  next_pc, redirect, redirect_pc, imem_ack, imem_data, id_stall,
        output pc_plus4, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output next_pc, redirect, redirect_pc, imem_ack, imem_data, id_stall,
        input  pc_plus4, imem_req, imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - MIPS32 instruction fetch: PC register, imem req/ack, IF/ID output with hold buffer
module ifetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input logic          clock,
    input logic          reset,
    ifetch_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] save_pc_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic        if_valid_q;
    logic        advance;

    assign advance       = !if_valid_q || !bus.id_stall;
    assign bus.imem_req  = (state_q == FETCH) || (state_q == DROP);
    assign bus.imem_addr = pc_q;
    assign bus.pc_plus4  = pc_q + 32'd4;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            save_pc_q    <= 32'd0;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
            if_instr_q   <= 32'd0;
            if_pc_q      <= 32'd0;
            if_valid_q   <= 1'b0;
        end else begin
            if (bus.redirect) begin
                if_valid_q   <= 1'b0;
                hold_instr_q <= 32'd0;
                hold_pc_q    <= 32'd0;
            end
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    if (bus.redirect) pc_q <= bus.redirect_pc;
                end
                FETCH: begin
                    if (bus.redirect) begin
                        // An un-acked request must complete before the new target is issued.
                        if (bus.imem_ack) begin
                            pc_q <= bus.redirect_pc;
                        end else begin
                            save_pc_q <= bus.redirect_pc;
                            state_q   <= DROP;
                        end
                    end else if (bus.imem_ack) begin
                        pc_q <= bus.next_pc;
                        if (advance) begin
                            if_instr_q <= bus.imem_data;
                            if_pc_q    <= pc_q;
                            if_valid_q <= 1'b1;
                        end else begin
                            hold_instr_q <= bus.imem_data;
                            hold_pc_q    <= pc_q;
                            state_q      <= HOLD;
                        end
                    end else if (advance) begin
                        if_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (bus.redirect) begin
                        pc_q    <= bus.redirect_pc;
                        state_q <= FETCH;
                    end else if (!bus.id_stall) begin
                        if_instr_q <= hold_instr_q;
                        if_pc_q    <= hold_pc_q;
                        if_valid_q <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                DROP: begin
                    if (bus.redirect) save_pc_q <= bus.redirect_pc;
                    if (bus.imem_ack) begin
                        pc_q    <= bus.redirect ? bus.redirect_pc : save_pc_q;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS32 core. Holds the architectural PC and issues word reads to instruction memory over a req/ack handshake. Presents fetched words to the IF/ID boundary with valid/stall flow control. Its next-PC input is driven by the 4-input PC-source multiplexer, whose pc+4 input this block supplies.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
next_pc  input  32  next PC from the PC-source mux; loaded on each accepted fetch
pc_plus4  output  32  pc + 4 modulo 2^32, combinational from the PC register; feeds mux input 0
redirect  input  1  flush the pipeline front and fetch from redirect_pc
redirect_pc  input  32  redirect target
imem_req  output  1  read request
imem_addr  output  32  read address, equal to the PC register
imem_ack  input  1  read data valid this cycle; may arrive in the same cycle as req
imem_data  input  32  read data
id_stall  input  1  decode cannot accept a new instruction this cycle
if_valid  output  1  if_instr and if_pc hold a live instruction
if_instr  output  32  fetched instruction
if_pc  output  32  address of if_instr

Behaviour:
- Reset (asynchronous):
  - pc = RESET_VECTOR; state = IDLE.
  - imem_req = 0; if_valid = 0; if_instr = 0; if_pc = 0; hold buffer empty.
- Output advance rule: output may advance = (!if_valid || !id_stall).
- States:
  - IDLE: imem_req = 0. Always moves to FETCH on the next cycle.
  - FETCH: imem_req = 1, imem_addr = pc, held stable until ack. On imem_ack:
    - If output may advance: if_instr <= imem_data, if_pc <= pc, if_valid <= 1, pc <= next_pc. Stay in FETCH.
    - Else: hold_instr/hold_pc <= imem_data/pc, pc <= next_pc, go to HOLD.
    - If no ack and output may advance: if_valid <= 0 (a consumed slot empties).
  - HOLD: imem_req = 0. When !id_stall: output <= hold buffer, if_valid <= 1, go to FETCH.
  - DROP: imem_req = 1, address held at the aborted PC. On ack the data is discarded, pc <= saved redirect target, go to FETCH.
- Throughput and latency:
  - Zero-wait memory (ack in the same cycle as req) with no stall: one instruction per cycle.
  - Latency from req to if_valid is 1 cycle after the ack edge.
- Redirect (highest priority, 1-cycle pulse):
  - if_valid <= 0 and the hold buffer is cleared.
  - In FETCH with no ack this cycle: save redirect_pc and go to DROP. The handshake is never abandoned mid-request.
  - In FETCH with ack this cycle: discard the data, pc <= redirect_pc, stay in FETCH.
  - In IDLE or HOLD: pc <= redirect_pc, go to FETCH.
  - In DROP: overwrite the saved target with redirect_pc.
- Ack while imem_req = 0 is ignored.
- pc_plus4 wraps: pc = 32'hFFFF_FFFC gives pc_plus4 = 32'h0000_0000.
- Reset mid-request drops imem_req immediately. Any later ack is ignored until FETCH is re-entered.
- id_stall while if_valid = 0 has no effect.

Test Plan:
- Reset with RESET_VECTOR=32'hBFC0_0000, then release, ack every cycle with data=addr^32'hFFFF, next_pc tied to pc_plus4 -> imem_addr steps BFC00000, BFC00004, ...; if_valid high from the 2nd edge after the first ack; if_instr = if_pc^32'hFFFF.
- Ack with 3 wait cycles -> imem_req and imem_addr held stable 4 cycles; if_valid low during waits; one instruction per 4 cycles.
- id_stall high for 5 cycles while the next ack arrives -> enters HOLD, imem_req = 0; if_instr/if_pc unchanged; the held word appears on the first edge after stall drops; no instruction lost or duplicated.
- Redirect to 32'h0000_0100 during an outstanding un-acked request at 32'h40 -> if_valid = 0; the ack for 0x40 is discarded; next request address is 0x100.
- Redirect in the same cycle as an ack, while HOLD is occupied -> the held and acked words are both discarded; fetch resumes at redirect_pc.
- pc = 32'hFFFF_FFFC -> pc_plus4 = 0; assert reset mid-FETCH -> imem_req = 0 and if_valid = 0 immediately, without waiting for a clock edge.
